// File: rtl/processor_8085_multi.sv
// Multi-cycle 8085-style accumulator core with a register file, cy/z flags and a single
// req/ack memory bus shared by instruction fetch, operand fetch and data access.
module processor_8085_multi #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_N  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc,
  output logic              cy,
  output logic              z,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              instr_done
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_OPER  = 3'd1,
    S_MEM   = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_MOVA = 4'h1;
  localparam logic [3:0] OP_MOVR = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_ANA  = 4'h5;
  localparam logic [3:0] OP_XRA  = 4'h6;
  localparam logic [3:0] OP_MVI  = 4'h7;
  localparam logic [3:0] OP_LDA  = 4'h8;
  localparam logic [3:0] OP_STA  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [3:0] REG_LIM = 4'(REG_N);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [DATA_W-1:0]   r_acc, w_acc_nxt;
  logic                r_cy, w_cy_nxt;
  logic                r_z, w_z_nxt;
  logic [3:0]          r_op, w_op_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_opr, w_opr_nxt;
  logic                r_req, w_req_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_halted;
  logic                r_done, w_done_nxt;
  logic                w_reg_we;
  logic [DATA_W-1:0]   r_regs [0:7];

  logic                w_ack;
  logic                w_rd_ok;
  logic [DATA_W-1:0]   w_rval;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   w_and;
  logic [DATA_W-1:0]   w_xor;
  logic [3:0]          w_fetch_op;
  logic                w_two_word;
  logic [ADDR_W-1:0]   w_pc_inc;

  // Indices at or beyond REG_N behave as a hardwired zero register
  assign w_ack      = r_req & mem_ack;
  assign w_rd_ok    = ({1'b0, r_idx} < REG_LIM);
  assign w_rval     = w_rd_ok ? r_regs[r_idx] : {DATA_W{1'b0}};
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_rval};
  assign w_diff     = r_acc - w_rval;
  assign w_and      = r_acc & w_rval;
  assign w_xor      = r_acc ^ w_rval;
  assign w_fetch_op = mem_rdata[7:4];
  assign w_two_word = (w_fetch_op >= OP_MVI) && (w_fetch_op <= OP_JC);
  assign w_pc_inc   = r_pc + ADDR_W'(1);

  // Next-state, datapath and next bus-request decode
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_cy_nxt    = r_cy;
    w_z_nxt     = r_z;
    w_op_nxt    = r_op;
    w_idx_nxt   = r_idx;
    w_opr_nxt   = r_opr;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_done_nxt  = 1'b0;
    w_reg_we    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!r_req) begin
          w_req_nxt  = 1'b1;
          w_we_nxt   = 1'b0;
          w_addr_nxt = r_pc;
        end else if (w_ack) begin
          w_op_nxt  = w_fetch_op;
          w_idx_nxt = mem_rdata[2:0];
          w_pc_nxt  = w_pc_inc;
          if (w_two_word) begin
            w_state_nxt = S_OPER;
            w_addr_nxt  = w_pc_inc;
          end else begin
            w_state_nxt = S_EXEC;
            w_req_nxt   = 1'b0;
          end
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_OPER: begin
        if (w_ack) begin
          w_opr_nxt = mem_rdata;
          w_pc_nxt  = w_pc_inc;
          if ((r_op == OP_LDA) || (r_op == OP_STA)) begin
            w_state_nxt = S_MEM;
            w_addr_nxt  = mem_rdata[ADDR_W-1:0];
            w_we_nxt    = (r_op == OP_STA);
            w_wdata_nxt = r_acc;
          end else begin
            w_state_nxt = S_EXEC;
            w_req_nxt   = 1'b0;
          end
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_MEM: begin
        if (w_ack) begin
          if (r_op == OP_LDA) begin
            w_acc_nxt = mem_rdata;
          end else begin
            w_acc_nxt = r_acc;
          end
          w_state_nxt = S_FETCH;
          w_done_nxt  = 1'b1;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = r_pc;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_EXEC: begin
        w_done_nxt = 1'b1;
        case (r_op)
          OP_MOVA: w_acc_nxt = w_rval;
          OP_MOVR: w_reg_we  = w_rd_ok;
          OP_ADD: begin
            w_acc_nxt = w_sum[DATA_W-1:0];
            w_cy_nxt  = w_sum[DATA_W];
            w_z_nxt   = (w_sum[DATA_W-1:0] == {DATA_W{1'b0}});
          end
          OP_SUB: begin
            w_acc_nxt = w_diff;
            w_cy_nxt  = (r_acc < w_rval);
            w_z_nxt   = (w_diff == {DATA_W{1'b0}});
          end
          OP_ANA: begin
            w_acc_nxt = w_and;
            w_cy_nxt  = 1'b0;
            w_z_nxt   = (w_and == {DATA_W{1'b0}});
          end
          OP_XRA: begin
            w_acc_nxt = w_xor;
            w_cy_nxt  = 1'b0;
            w_z_nxt   = (w_xor == {DATA_W{1'b0}});
          end
          OP_MVI:  w_acc_nxt = r_opr;
          OP_JMP:  w_pc_nxt  = r_opr[ADDR_W-1:0];
          OP_JZ:   w_pc_nxt  = r_z ? r_opr[ADDR_W-1:0] : r_pc;
          OP_JC:   w_pc_nxt  = r_cy ? r_opr[ADDR_W-1:0] : r_pc;
          default: w_pc_nxt  = r_pc;
        endcase
        // Launch the next fetch in the retiring edge so a 1-word op costs two cycles
        if (r_op == OP_HLT) begin
          w_state_nxt = S_HALT;
          w_req_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = w_pc_nxt;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
        w_req_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // State, architectural registers and registered bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= {ADDR_W{1'b0}};
      r_acc    <= {DATA_W{1'b0}};
      r_cy     <= 1'b0;
      r_z      <= 1'b0;
      r_op     <= 4'h0;
      r_idx    <= 3'd0;
      r_opr    <= {DATA_W{1'b0}};
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_wdata  <= {DATA_W{1'b0}};
      r_halted <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_acc    <= w_acc_nxt;
      r_cy     <= w_cy_nxt;
      r_z      <= w_z_nxt;
      r_op     <= w_op_nxt;
      r_idx    <= w_idx_nxt;
      r_opr    <= w_opr_nxt;
      r_req    <= w_req_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_halted <= (w_state_nxt == S_HALT);
      r_done   <= w_done_nxt;
      if (w_reg_we) begin
        r_regs[r_idx] <= r_acc;
      end
    end
  end

  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign acc        = r_acc;
  assign cy         = r_cy;
  assign z          = r_z;
  assign pc_out     = r_pc;
  assign halted     = r_halted;
  assign instr_done = r_done;

endmodule

// File: tb/tb_processor_8085_multi.sv
// Bench for processor_8085_multi: directed program table, hand-written latency/reset/wrap
// sequences, and random forward-jump programs checked against an instruction-level model.
module tb_processor_8085_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic       req8, we8, cy8, z8, halted8, done8;
  logic       ack8 = 1'b0;
  logic [7:0] addr8, wdata8, acc8, pc8;
  logic [7:0] rdata8 = 8'h00;
  logic        req16, we16, cy16, z16, halted16, done16;
  logic        ack16 = 1'b0;
  logic [7:0]  addr16, pc16;
  logic [15:0] wdata16, acc16;
  logic [15:0] rdata16 = 16'h0000;

  processor_8085_multi #(.DATA_W(8), .ADDR_W(8), .REG_N(7)) u8 (
    .clk(clk), .rst_n(rst_n), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
    .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8), .acc(acc8), .cy(cy8),
    .z(z8), .pc_out(pc8), .halted(halted8), .instr_done(done8));

  processor_8085_multi #(.DATA_W(16), .ADDR_W(8), .REG_N(7)) u16 (
    .clk(clk), .rst_n(rst_n), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ack(ack16), .acc(acc16), .cy(cy16),
    .z(z16), .pc_out(pc16), .halted(halted16), .instr_done(done16));

  logic [7:0]  mem8  [0:255];
  logic [15:0] mem16 [0:255];
  logic [7:0]  img   [0:255];
  int          mm    [0:255];
  int waits8 = 0;
  bit rnd8 = 1'b0;
  int cnt8 = 0, cur8 = 0;
  int tests = 0, fails = 0;

  // Memory with configurable (or random) wait states; acts half a cycle before the DUT edge
  always @(negedge clk) begin
    if (ack8 || !req8) begin
      cnt8 = 0;
      cur8 = rnd8 ? int'($urandom_range(0, 2)) : waits8;
    end
    if (req8) begin
      if (cnt8 >= cur8) begin
        ack8   = 1'b1;
        rdata8 = mem8[addr8];
        if (we8) mem8[addr8] = wdata8;
      end else begin
        ack8   = 1'b0;
        rdata8 = 8'($urandom);
        cnt8++;
      end
    end else begin
      ack8 = 1'b0;
    end
  end

  // Zero-wait memory for the 16-bit instance
  always @(negedge clk) begin
    ack16 = (req16 === 1'b1);
    if (req16 === 1'b1) begin
      rdata16 = mem16[addr16];
      if (we16) mem16[addr16] = wdata16;
    end
  end

  typedef struct {
    logic [255:0] prog;
    int plen, waits, acc, cy, z, pc, nd, m41;
  } vec_t;
  vec_t vecs [0:8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[8'h40] = 8'h03;
    for (int i = 0; i < v.plen; i++) img[i] = v.prog[8*(v.plen-1-i) +: 8];
    for (int i = 0; i < 256; i++) mem8[i] = img[i];
  endtask

  task automatic run_wait(output int nd, output bit ok);
    nd = 0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done8) nd++;
      if (halted8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Cycles from the first request until the first retirement pulse, and how many had req low
  task automatic measure(output int n, output int nlow);
    n = 0;
    nlow = 0;
    for (int c = 0; c < 50 && !req8; c++) @(negedge clk);
    while (!done8 && n < 200) begin
      n++;
      if (!req8) nlow++;
      @(negedge clk);
    end
  endtask

  // Instruction-level reference: runs the image until HLT
  task automatic model_run(output int macc, output int mcy, output int mz, output int mpc,
                           output int mcnt);
    int regs [0:6];
    int pc, ir, op, r, rv, w, s;
    bit stop;
    for (int i = 0; i < 7; i++) regs[i] = 0;
    for (int i = 0; i < 256; i++) mm[i] = int'(img[i]);
    pc = 0; macc = 0; mcy = 0; mz = 0; mcnt = 0; stop = 1'b0;
    for (int step = 0; step < 500 && !stop; step++) begin
      ir = mm[pc]; pc = (pc + 1) % 256;
      op = ir / 16; r = ir % 8;
      rv = (r < 7) ? regs[r] : 0;
      w = 0;
      if (op >= 7 && op <= 12) begin
        w = mm[pc]; pc = (pc + 1) % 256;
      end
      mcnt++;
      case (op)
        1:  macc = rv;
        2:  if (r < 7) regs[r] = macc;
        3:  begin s = macc + rv; mcy = (s > 255) ? 1 : 0; macc = s % 256; mz = (macc == 0) ? 1 : 0; end
        4:  begin mcy = (macc < rv) ? 1 : 0; macc = (macc - rv + 256) % 256; mz = (macc == 0) ? 1 : 0; end
        5:  begin macc = macc & rv; mcy = 0; mz = (macc == 0) ? 1 : 0; end
        6:  begin macc = macc ^ rv; mcy = 0; mz = (macc == 0) ? 1 : 0; end
        7:  macc = w;
        8:  macc = mm[w];
        9:  mm[w] = macc;
        10: pc = w;
        11: if (mz != 0) pc = w;
        12: if (mcy != 0) pc = w;
        15: stop = 1'b1;
        default: ;
      endcase
    end
    mpc = pc;
  endtask

  // Random straight-line program with forward-only jumps, ending in HLT
  task automatic gen_prog();
    int n, a;
    int ops [0:19];
    int adr [0:20];
    n = $urandom_range(4, 18);
    a = 0;
    for (int i = 0; i < n; i++) begin
      ops[i] = $urandom_range(0, 14);
      adr[i] = a;
      a += (ops[i] >= 7 && ops[i] <= 12) ? 2 : 1;
    end
    adr[n] = a;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 128; i < 144; i++) img[i] = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      img[adr[i]] = 8'(ops[i] * 16 + $urandom_range(0, 15));
      case (ops[i])
        7:          img[adr[i]+1] = 8'($urandom);
        8, 9:       img[adr[i]+1] = 8'(128 + $urandom_range(0, 15));
        10, 11, 12: img[adr[i]+1] = 8'(adr[$urandom_range(i + 1, n)]);
        default: ;
      endcase
    end
    img[adr[n]] = 8'(240 + $urandom_range(0, 15));
    for (int i = 0; i < 256; i++) mem8[i] = img[i];
  endtask

  initial begin
    int nd, n, nlow, macc, mcy, mz, mpc, mcnt, nbad, cnt;
    bit ok;
    logic [31:0] lat_prog [0:4];
    int lat_w [0:4], lat_n [0:4], lat_low [0:4];

    for (int i = 0; i < 256; i++) mem16[i] = 16'h0000;
    mem16[0] = 16'hAB70; mem16[1] = 16'h0001; mem16[2] = 16'h3C20; mem16[3] = 16'h5570;
    mem16[4] = 16'hFFFF; mem16[5] = 16'h0030; mem16[6] = 16'h00F0;

    vecs[0] = '{256'({8'h70,8'h01,8'h20,8'h70,8'h02,8'h21,8'h70,8'h03,8'h22,8'h70,8'h04,8'h23,
                      8'h70,8'h05,8'h24,8'h70,8'h06,8'h25,8'h70,8'h07,8'h26,8'h70,8'h00,
                      8'h30,8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'hF0}),
                31, 0, 28, 0, 0, 31, 23, 0};
    vecs[1] = '{256'({8'h70,8'h01,8'h20,8'h70,8'hFF,8'h30,8'hF0}), 7, 0, 8'h00, 1, 1, 7, 5, 0};
    vecs[2] = '{256'({8'h70,8'h01,8'h20,8'h70,8'hFF,8'h30,8'h40,8'hF0}), 8, 0, 8'hFF, 1, 0, 8, 6, 0};
    vecs[3] = '{256'({8'h80,8'h40,8'h90,8'h41,8'hF0}), 5, 0, 3, 0, 0, 5, 3, 3};
    vecs[4] = '{256'({8'h80,8'h40,8'h90,8'h41,8'hF0}), 5, 2, 3, 0, 0, 5, 3, 3};
    vecs[5] = '{256'({8'h70,8'h01,8'h20,8'h70,8'h03,8'h40,8'hB0,8'h0A,8'hA0,8'h05,8'hF0}),
                11, 1, 0, 0, 1, 11, 12, 0};
    vecs[6] = '{256'({8'h70,8'h05,8'h27,8'h17,8'hF0}), 5, 0, 0, 0, 0, 5, 4, 0};
    vecs[7] = '{256'({8'h70,8'h01,8'h20,8'h70,8'h00,8'h40,8'h70,8'hF0,8'h21,8'h70,8'h3C,
                      8'h51,8'h61,8'hF0}), 14, 0, 8'hC0, 0, 0, 14, 10, 0};
    vecs[8] = '{256'({8'h70,8'h01,8'h20,8'h70,8'h00,8'h40,8'hC0,8'h0A,8'h70,8'h55,8'hF0}),
                11, 0, 8'hFF, 1, 0, 11, 6, 0};

    for (int i = 0; i < 9; i++) begin
      load_vec(vecs[i]);
      waits8 = vecs[i].waits;
      rnd8 = 1'b0;
      do_reset();
      run_wait(nd, ok);
      check($sformatf("vec%0d_halted", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_acc", i), 32'(acc8), 32'(vecs[i].acc));
      check($sformatf("vec%0d_cy", i), 32'(cy8), 32'(vecs[i].cy));
      check($sformatf("vec%0d_z", i), 32'(z8), 32'(vecs[i].z));
      check($sformatf("vec%0d_pc", i), 32'(pc8), 32'(vecs[i].pc));
      check($sformatf("vec%0d_ndone", i), 32'(nd), 32'(vecs[i].nd));
      check($sformatf("vec%0d_mem41", i), 32'(mem8[8'h41]), 32'(vecs[i].m41));
    end

    check("w16_halted", 32'(halted16), 32'd1);
    check("w16_acc", 32'(acc16), 32'h0000);
    check("w16_cy", 32'(cy16), 32'd1);
    check("w16_z", 32'(z16), 32'd1);
    check("w16_pc", 32'(pc16), 32'd7);

    // Reset asserted while the LDA fetch is stalled on wait states
    load_vec('{256'({8'h70,8'h55,8'h80,8'h40,8'hF0}), 5, 4, 0, 0, 0, 0, 0, 0});
    waits8 = 4;
    do_reset();
    for (int c = 0; c < 100 && !done8; c++) @(negedge clk);
    check("rst_pre_acc", 32'(acc8), 32'h55);
    check("rst_pre_req", 32'(req8), 32'd1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", 32'(pc8), 32'd0);
    check("rst_acc", 32'(acc8), 32'd0);
    check("rst_cy", 32'(cy8), 32'd0);
    check("rst_z", 32'(z8), 32'd0);
    check("rst_req", 32'(req8), 32'd0);
    check("rst_halted", 32'(halted8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    rst_n = 1'b1;
    run_wait(nd, ok);
    check("rst_recover_acc", 32'(acc8), 32'h03);
    check("rst_recover_nd", 32'(nd), 32'd3);

    // First-instruction latency and request-low cycles
    lat_prog[0] = {8'h00, 8'hF0, 8'h00, 8'h00}; lat_w[0] = 0; lat_n[0] = 2; lat_low[0] = 1;
    lat_prog[1] = {8'h80, 8'h40, 8'hF0, 8'h00}; lat_w[1] = 2; lat_n[1] = 9; lat_low[1] = 0;
    lat_prog[2] = {8'h70, 8'h11, 8'hF0, 8'h00}; lat_w[2] = 1; lat_n[2] = 5; lat_low[2] = 1;
    lat_prog[3] = {8'h90, 8'h41, 8'hF0, 8'h00}; lat_w[3] = 0; lat_n[3] = 3; lat_low[3] = 0;
    lat_prog[4] = {8'hA0, 8'h02, 8'hF0, 8'h00}; lat_w[4] = 0; lat_n[4] = 3; lat_low[4] = 1;
    for (int i = 0; i < 5; i++) begin
      load_vec('{256'(lat_prog[i]), 4, 0, 0, 0, 0, 0, 0, 0});
      waits8 = lat_w[i];
      do_reset();
      measure(n, nlow);
      check($sformatf("lat%0d_cycles", i), 32'(n), 32'(lat_n[i]));
      check($sformatf("lat%0d_reqlow", i), 32'(nlow), 32'(lat_low[i]));
    end

    // PC wrap: JMP FF lands on a NOP at the top of memory
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
    mem8[0] = 8'hA0; mem8[1] = 8'hFF;
    waits8 = 0;
    do_reset();
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done8) begin
        cnt++;
        if (cnt == 1) check("wrap_pc_jmp", 32'(pc8), 32'hFF);
        if (cnt == 2) begin
          check("wrap_pc_nop", 32'(pc8), 32'h00);
          break;
        end
      end
    end
    check("wrap_pulses", 32'(cnt), 32'd2);

    // Random programs with random wait states
    rnd8 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      gen_prog();
      model_run(macc, mcy, mz, mpc, mcnt);
      do_reset();
      run_wait(nd, ok);
      nbad = 0;
      for (int a = 128; a < 144; a++) if (int'(mem8[a]) != mm[a]) nbad++;
      check($sformatf("rnd%0d_halted", t), 32'(ok), 32'd1);
      check($sformatf("rnd%0d_acc", t), 32'(acc8), 32'(macc));
      check($sformatf("rnd%0d_cy", t), 32'(cy8), 32'(mcy));
      check($sformatf("rnd%0d_z", t), 32'(z8), 32'(mz));
      check($sformatf("rnd%0d_pc", t), 32'(pc8), 32'(mpc));
      check($sformatf("rnd%0d_ndone", t), 32'(nd), 32'(mcnt));
      check($sformatf("rnd%0d_datamem", t), 32'(nbad), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
